// File: rtl/video_pkg.sv
// Shared video-pipeline constants and the pixel packer state encoding.
package video_pkg;
   localparam int RGB_W         = 24;
   localparam int DATA_W        = 32;
   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;

   // Rn = number of residual bytes held; FLUSH drains the tail of a line.
   typedef enum logic [2:0] {R0, R3, R2, R1, FLUSH} pack_state_t;
endpackage

// File: rtl/pixel_word_packer.sv
// Packs 24-bit RGB pixels densely into 32-bit little-endian stream words
// (4 pixels -> 3 words), zero-padding the tail of each line.
module pixel_word_packer #(
   parameter int RGB_W       = video_pkg::RGB_W,
   parameter int DATA_W      = video_pkg::DATA_W,
   parameter int LINE_PIXELS = video_pkg::SCREEN_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RGB_W-1:0]  in_colour,
   input  logic              in_sof,
   input  logic              in_eol,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sof,
   output logic              out_eol,
   output logic              err_len
);
   import video_pkg::*;

   localparam int             CNT_W    = $clog2(LINE_PIXELS + 1);
   localparam logic [CNT_W:0] LINE_LEN = (CNT_W + 1)'(LINE_PIXELS);
   localparam logic [CNT_W:0] ONE      = (CNT_W + 1)'(1);

   pack_state_t       state_reg, state_next;
   logic [RGB_W-1:0]  res_reg, res_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              sof_pend_reg, sof_pend_next;
   logic              err_reg, err_next;
   logic              out_valid_reg, out_valid_next;
   logic [DATA_W-1:0] out_data_reg, out_data_next;
   logic              out_sof_reg, out_sof_next;
   logic              out_eol_reg, out_eol_next;

   logic              out_free;
   logic              in_fire;
   pack_state_t       eff_state;
   logic              sof_pend;
   logic [CNT_W:0]    count_base;
   logic [CNT_W:0]    count_inc;

   assign out_free  = !out_valid_reg || out_ready;
   assign in_ready  = !reset && (state_reg != FLUSH) && out_free;
   assign in_fire   = in_valid && in_ready;

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sof   = out_sof_reg;
   assign out_eol   = out_eol_reg;
   assign err_len   = err_reg;

   // A new frame restarts the line count along with the byte alignment.
   assign count_base = in_sof ? '0 : {1'b0, count_reg};
   assign count_inc  = count_base + ONE;

   always_comb begin
      state_next     = state_reg;
      res_next       = res_reg;
      count_next     = count_reg;
      sof_pend_next  = sof_pend_reg;
      err_next       = err_reg;
      out_valid_next = out_valid_reg && !out_ready;
      out_data_next  = out_data_reg;
      out_sof_next   = out_sof_reg;
      out_eol_next   = out_eol_reg;
      eff_state      = state_reg;
      sof_pend       = sof_pend_reg;

      if (state_reg == FLUSH) begin
         if (out_free) begin
            // Residual is stored zero-extended, so it is already the padded word.
            out_valid_next = 1'b1;
            out_data_next  = {8'h00, res_reg};
            out_sof_next   = 1'b0;
            out_eol_next   = 1'b1;
            res_next       = '0;
            state_next     = R0;
         end
      end else if (in_fire) begin
         if (in_sof) begin
            if (state_reg != R0) begin
               err_next = 1'b1;
            end
            eff_state = R0;
            sof_pend  = 1'b1;
         end

         if (in_eol) begin
            count_next = '0;
            if (count_inc != LINE_LEN) begin
               err_next = 1'b1;
            end
         end else if (count_inc >= LINE_LEN) begin
            err_next   = 1'b1;
            count_next = LINE_LEN[CNT_W-1:0];
         end else begin
            count_next = count_inc[CNT_W-1:0];
         end

         case (eff_state)
            R0: begin
               if (in_eol) begin
                  out_valid_next = 1'b1;
                  out_data_next  = {8'h00, in_colour};
                  out_sof_next   = sof_pend;
                  out_eol_next   = 1'b1;
                  sof_pend_next  = 1'b0;
                  res_next       = '0;
                  state_next     = R0;
               end else begin
                  sof_pend_next  = sof_pend;
                  res_next       = in_colour;
                  state_next     = R3;
               end
            end
            R3: begin
               out_valid_next = 1'b1;
               out_data_next  = {in_colour[7:0], res_reg};
               out_sof_next   = sof_pend;
               out_eol_next   = 1'b0;
               sof_pend_next  = 1'b0;
               res_next       = {8'h00, in_colour[23:8]};
               state_next     = in_eol ? FLUSH : R2;
            end
            R2: begin
               out_valid_next = 1'b1;
               out_data_next  = {in_colour[15:0], res_reg[15:0]};
               out_sof_next   = sof_pend;
               out_eol_next   = 1'b0;
               sof_pend_next  = 1'b0;
               res_next       = {16'h0000, in_colour[23:16]};
               state_next     = in_eol ? FLUSH : R1;
            end
            R1: begin
               out_valid_next = 1'b1;
               out_data_next  = {in_colour, res_reg[7:0]};
               out_sof_next   = sof_pend;
               out_eol_next   = in_eol;
               sof_pend_next  = 1'b0;
               res_next       = '0;
               state_next     = R0;
            end
            default: begin
               state_next = R0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= R0;
         res_reg       <= '0;
         count_reg     <= '0;
         sof_pend_reg  <= 1'b0;
         err_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sof_reg   <= 1'b0;
         out_eol_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         res_reg       <= res_next;
         count_reg     <= count_next;
         sof_pend_reg  <= sof_pend_next;
         err_reg       <= err_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_sof_reg   <= out_sof_next;
         out_eol_reg   <= out_eol_next;
      end
   end
endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: byte-queue reference model, table of short
// lines, and hand sequences for SOF drop, reset during FLUSH and overlong lines.
module tb_pixel_word_packer;
   localparam int LINE = 640;

   typedef struct packed {
      logic [31:0] data;
      logic        sof;
      logic        eol;
   } word_t;

   typedef struct {
      int          npix;
      logic [23:0] px [5];
      int          exp_words;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_colour = '0;
   logic        in_sof = 1'b0;
   logic        in_eol = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_sof;
   logic        out_eol;
   logic        err_len;

   int checks = 0;
   int failures = 0;
   int ready_mode = 0;

   // Reference model state
   logic [8:0]  byte_q [$];
   word_t       exp_q [$];
   word_t       cap_q [$];
   logic [31:0] ref_seq [$];
   int          m_count = 0;
   logic        m_err = 1'b0;
   logic        hold_valid = 1'b0;
   word_t       hold_w;
   word_t       mon_w;
   vec_t        tbl [4];

   always #5 clk = ~clk;

   pixel_word_packer #(.LINE_PIXELS(LINE)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_colour(in_colour),
      .in_sof(in_sof), .in_eol(in_eol),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sof(out_sof), .out_eol(out_eol), .err_len(err_len)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Bytes go out little-endian in arrival order; a line's tail is zero-padded.
   function automatic void model_accept(input logic [23:0] c, input logic s, input logic e);
      logic [8:0] b;
      word_t w;
      if (s) begin
         if (byte_q.size() != 0) m_err = 1'b1;
         byte_q.delete();
         m_count = 0;
      end
      for (int k = 0; k < 3; k++) begin
         b = {(s && k == 0), c[8*k +: 8]};
         byte_q.push_back(b);
      end
      m_count++;
      if (e) begin
         if (m_count != LINE) m_err = 1'b1;
         m_count = 0;
      end else if (m_count >= LINE) begin
         m_err = 1'b1;
      end
      while (byte_q.size() >= 4 || (e && byte_q.size() > 0)) begin
         w = '0;
         for (int k = 0; k < 4; k++) begin
            if (byte_q.size() > 0) begin
               b = byte_q.pop_front();
               w.data[8*k +: 8] = b[7:0];
               w.sof = w.sof | b[8];
            end
         end
         exp_q.push_back(w);
      end
      if (e) begin
         w = exp_q.pop_back();
         w.eol = 1'b1;
         exp_q.push_back(w);
      end
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         byte_q.delete();
         exp_q.delete();
         m_count = 0;
         m_err = 1'b0;
         hold_valid = 1'b0;
      end else begin
         chk("err_len", {31'd0, err_len}, {31'd0, m_err});
         if (hold_valid) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, hold_w.data);
            chk("hold_flags", {30'd0, out_sof, out_eol}, {30'd0, hold_w.sof, hold_w.eol});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got 0x%08h expected none", out_data);
            end else begin
               mon_w = exp_q.pop_front();
               chk("word_data", out_data, mon_w.data);
               chk("word_flags", {30'd0, out_sof, out_eol}, {30'd0, mon_w.sof, mon_w.eol});
            end
            cap_q.push_back({out_data, out_sof, out_eol});
         end
         hold_valid = out_valid && !out_ready;
         hold_w = {out_data, out_sof, out_eol};
         if (in_valid && in_ready) model_accept(in_colour, in_sof, in_eol);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic send_pixel(input logic [23:0] c, input logic s, input logic e);
      int budget;
      budget = 0;
      in_colour = c;
      in_sof = s;
      in_eol = e;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready) begin
         budget++;
         if (budget > 1000) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 1000 cycles");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_eol = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      @(negedge clk);
      while (exp_q.size() != 0 || out_valid) begin
         budget++;
         if (budget > 10000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending words expected 0", exp_q.size());
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_line(input int n, input logic [23:0] base);
      for (int i = 0; i < n; i++)
         send_pixel(base + 24'(i), (i == 0), (i == n - 1));
   endtask

   initial begin
      int sofs, eols;
      tbl[0] = '{1, '{24'hAABBCC, 24'h0, 24'h0, 24'h0, 24'h0}, 1, 32'h00AABBCC, 32'h00AABBCC};
      tbl[1] = '{2, '{24'h112233, 24'h445566, 24'h0, 24'h0, 24'h0}, 2, 32'h66112233, 32'h00004455};
      tbl[2] = '{3, '{24'h010203, 24'h040506, 24'h070809, 24'h0, 24'h0}, 3, 32'h06010203, 32'h00000007};
      tbl[3] = '{5, '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 24'hDEADBE}, 4, 32'h06010203, 32'h00DEADBE};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_flags", {29'd0, out_sof, out_eol, err_len}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Full line without stalls
      ready_mode = 1;
      cap_q.delete();
      send_line(LINE, 24'h000001);
      drain();
      chk("full_words", cap_q.size(), 480);
      sofs = 0;
      eols = 0;
      foreach (cap_q[i]) begin
         sofs += int'(cap_q[i].sof);
         eols += int'(cap_q[i].eol);
         ref_seq.push_back(cap_q[i].data);
      end
      if (cap_q.size() == 480) begin
         chk("full_word0", cap_q[0].data, 32'h02000001);
         chk("full_sof0", {31'd0, cap_q[0].sof}, 32'd1);
         chk("full_eol479", {31'd0, cap_q[479].eol}, 32'd1);
      end
      chk("full_sof_count", sofs, 1);
      chk("full_eol_count", eols, 1);
      chk("full_err", {31'd0, err_len}, 32'd0);

      // Two lines under random backpressure must reproduce the same stream
      ready_mode = 2;
      cap_q.delete();
      send_line(LINE, 24'h000001);
      send_line(LINE, 24'h000001);
      ready_mode = 1;
      drain();
      chk("stall_words", cap_q.size(), 960);
      foreach (cap_q[i]) chk("stall_seq", cap_q[i].data, ref_seq[i % 480]);
      chk("stall_err", {31'd0, err_len}, 32'd0);

      // Short lines
      for (int t = 0; t < 4; t++) begin
         cap_q.delete();
         for (int i = 0; i < tbl[t].npix; i++)
            send_pixel(tbl[t].px[i], (i == 0), (i == tbl[t].npix - 1));
         drain();
         chk($sformatf("short%0d_words", tbl[t].npix), cap_q.size(), tbl[t].exp_words);
         if (cap_q.size() > 0) begin
            chk($sformatf("short%0d_first", tbl[t].npix), cap_q[0].data, tbl[t].exp_first);
            chk($sformatf("short%0d_last", tbl[t].npix), cap_q[cap_q.size()-1].data, tbl[t].exp_last);
            chk($sformatf("short%0d_eol", tbl[t].npix), {31'd0, cap_q[cap_q.size()-1].eol}, 32'd1);
         end
         chk($sformatf("short%0d_err", tbl[t].npix), {31'd0, err_len}, 32'd1);
      end

      // SOF arriving in R2 drops the residual
      do_reset();
      cap_q.delete();
      send_pixel(24'h010203, 1'b1, 1'b0);
      send_pixel(24'h040506, 1'b0, 1'b0);
      chk("sofdrop_err_before", {31'd0, err_len}, 32'd0);
      send_pixel(24'hA1B2C3, 1'b1, 1'b0);
      chk("sofdrop_err_after", {31'd0, err_len}, 32'd1);
      send_pixel(24'hD4E5F6, 1'b0, 1'b1);
      drain();
      chk("sofdrop_words", cap_q.size(), 3);
      if (cap_q.size() == 3) begin
         chk("sofdrop_w0", cap_q[0].data, 32'h06010203);
         chk("sofdrop_w1", cap_q[1].data, 32'hF6A1B2C3);
         chk("sofdrop_w1_sof", {31'd0, cap_q[1].sof}, 32'd1);
         chk("sofdrop_w2", cap_q[2].data, 32'h0000D4E5);
         chk("sofdrop_w2_eol", {31'd0, cap_q[2].eol}, 32'd1);
      end

      // Reset while stuck in FLUSH
      ready_mode = 0;
      @(posedge clk);
      #1;
      send_pixel(24'h111111, 1'b1, 1'b0);
      send_pixel(24'h222222, 1'b0, 1'b1);
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      chk("flushrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flushrst_in_ready", {31'd0, in_ready}, 32'd1);
      ready_mode = 1;
      @(posedge clk);
      #1;
      cap_q.delete();
      send_line(4, 24'h300000);
      drain();
      chk("flushrst_words", cap_q.size(), 3);

      // Randomised traffic against the model
      ready_mode = 2;
      for (int i = 0; i < 400; i++) begin
         send_pixel(24'($urandom), ($urandom_range(0, 19) == 0),
                    (i == 399) || ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      ready_mode = 1;
      drain();

      // Overlong line: err_len rises as the count reaches LINE, packing continues
      do_reset();
      cap_q.delete();
      for (int i = 0; i < 700; i++) begin
         send_pixel(24'(i + 1), (i == 0), 1'b0);
         if (i == LINE - 2) chk("long_err_639", {31'd0, err_len}, 32'd0);
         if (i == LINE - 1) chk("long_err_640", {31'd0, err_len}, 32'd1);
      end
      drain();
      chk("long_words", cap_q.size(), 525);
      chk("long_err_end", {31'd0, err_len}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
